// File: rtl/alu_pkg.sv
// alu_pkg: shared BCD constants and the digit-serial subtractor state type
package alu_pkg;

    typedef enum logic [1:0] {DS_IDLE, DS_RUN, DS_DONE} dsub_state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int BCD_RADIX = 10;

endpackage

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: one BCD digit of a - b - borrow, with borrow out and non-BCD flag
module bcd_digit_sub
    import alu_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a_i,
    input  logic [BCD_DIGIT_W-1:0] b_i,
    input  logic                   br_i,
    output logic [BCD_DIGIT_W-1:0] digit_o,
    output logic                   br_o,
    output logic                   err_o
);

    logic [5:0] diff;
    logic [5:0] fixed;

    // a negative raw difference borrows one radix from the next digit
    always_comb begin
        diff = {2'b00, a_i} - {2'b00, b_i} - {5'd0, br_i};
        fixed = diff + 6'(BCD_RADIX);
        br_o = diff[5];
        digit_o = diff[5] ? fixed[3:0] : diff[3:0];
        err_o = (a_i > BCD_MAX) | (b_i > BCD_MAX);
    end

endmodule

// File: rtl/alu_dsub_serial.sv
// alu_dsub_serial: digit-serial BCD subtractor, LS digit first, start/busy/done handshake
module alu_dsub_serial
    import alu_pkg::*;
#(
    parameter int NDIGITS = 4,
    localparam int W = BCD_DIGIT_W * NDIGITS,
    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         borrow_in_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] result_o,
    output logic         borrow_out_o,
    output logic         zero_o,
    output logic         bcd_err_o
);

    dsub_state_t state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0] a_q, b_q, result_q, result_d;
    logic br_q, busy_q, done_q, borrow_out_q, zero_q, bcd_err_q;
    logic [BCD_DIGIT_W-1:0] digit;
    logic br_nx, err;
    logic last;

    bcd_digit_sub u_digit (
        .a_i     (a_q[BCD_DIGIT_W*cnt_q +: BCD_DIGIT_W]),
        .b_i     (b_q[BCD_DIGIT_W*cnt_q +: BCD_DIGIT_W]),
        .br_i    (br_q),
        .digit_o (digit),
        .br_o    (br_nx),
        .err_o   (err)
    );

    // result with the current digit dropped into its slot
    always_comb begin
        result_d = result_q;
        result_d[BCD_DIGIT_W*cnt_q +: BCD_DIGIT_W] = digit;
        last = cnt_q == CW'(NDIGITS - 1);
    end

    // handshake FSM, digit counter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DS_IDLE;
            cnt_q <= '0;
            a_q <= '0;
            b_q <= '0;
            br_q <= 1'b0;
            result_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            borrow_out_q <= 1'b0;
            zero_q <= 1'b0;
            bcd_err_q <= 1'b0;
        end else begin
            case (state_q)
                DS_RUN: begin
                    result_q <= result_d;
                    br_q <= br_nx;
                    bcd_err_q <= bcd_err_q | err;
                    if (last) begin
                        state_q <= DS_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        borrow_out_q <= br_nx;
                        zero_q <= result_d == '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DS_IDLE, DS_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= DS_RUN;
                        busy_q <= 1'b1;
                        a_q <= a_i;
                        b_q <= b_i;
                        br_q <= borrow_in_i;
                        cnt_q <= '0;
                        result_q <= '0;
                        zero_q <= 1'b0;
                        bcd_err_q <= 1'b0;
                    end else begin
                        state_q <= DS_IDLE;
                    end
                end
                default: state_q <= DS_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign result_o = result_q;
    assign borrow_out_o = borrow_out_q;
    assign zero_o = zero_q;
    assign bcd_err_o = bcd_err_q;

endmodule
